// File: rtl/md5_batch_ctrl_if.sv
// Host, stream and match-block signals of the MD5 batch sequencer.
// Handshake: a stream byte moves on a rising clk edge where s_valid and s_ready
// are both high; s_data must be stable while s_valid is high, and s_ready may
// depend only on controller state, never combinationally on s_valid.
interface md5_batch_ctrl_if;
    logic         cmd_start;
    logic         cmd_abort;
    logic [31:0]  cmd_num_bytes;
    logic [5:0]   cmd_str_len;
    logic [127:0] cmd_target_hash;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic         proc_start;
    logic [7:0]   proc_data;
    logic         proc_data_valid;
    logic [127:0] proc_target_hash;
    logic [15:0]  proc_str_len;
    logic         proc_last;
    logic         proc_match_char_next;
    logic         proc_done;
    logic         proc_match;
    logic [31:0]  proc_byte_pos;
    logic [7:0]   proc_match_char;
    logic [7:0]   res_char;
    logic         res_char_valid;
    logic         res_valid;
    logic         res_match;
    logic [31:0]  res_byte_pos;
    logic         busy;
    logic         err;
    logic [2:0]   dbg_state;

    // Controller view.
    modport slave (
        input  cmd_start, cmd_abort, cmd_num_bytes, cmd_str_len, cmd_target_hash,
        input  s_data, s_valid,
        input  proc_done, proc_match, proc_byte_pos, proc_match_char,
        output s_ready, proc_start, proc_data, proc_data_valid, proc_target_hash,
        output proc_str_len, proc_last, proc_match_char_next,
        output res_char, res_char_valid, res_valid, res_match, res_byte_pos,
        output busy, err, dbg_state
    );

    // Host / match-block view.
    modport master (
        output cmd_start, cmd_abort, cmd_num_bytes, cmd_str_len, cmd_target_hash,
        output s_data, s_valid,
        output proc_done, proc_match, proc_byte_pos, proc_match_char,
        input  s_ready, proc_start, proc_data, proc_data_valid, proc_target_hash,
        input  proc_str_len, proc_last, proc_match_char_next,
        input  res_char, res_char_valid, res_valid, res_match, res_byte_pos,
        input  busy, err, dbg_state
    );
endinterface

// File: rtl/md5_batch_ctrl.sv
// Batch sequencer for one string_process_match block and its MD5 core:
// start pulse, byte forwarding, pipeline drain, end pulse, match readout, report.
module md5_batch_ctrl #(
    parameter int DRAIN_CYCLES  = 66,
    parameter int MAX_STR_BYTES = 55,
    parameter int DONE_TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             reset,
    md5_batch_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, START, STREAM, DRAIN, LAST, WAIT_DONE, READOUT, REPORT
    } state_t;

    state_t       state_q, state_d;
    logic         abort_q, abort_d;      // LAST entered through abort returns to IDLE
    logic [31:0]  num_bytes_q;
    logic [5:0]   str_len_q;
    logic [127:0] target_q;
    logic [15:0]  proc_str_len_q;
    logic [31:0]  byte_cnt_q;
    logic [31:0]  drain_cnt_q;
    logic [31:0]  to_cnt_q;
    logic [5:0]   char_cnt_q;
    logic [7:0]   proc_data_q;
    logic         proc_data_valid_q;
    logic [7:0]   res_char_q;
    logic         res_char_valid_q;
    logic         res_match_q;
    logic [31:0]  res_byte_pos_q;
    logic         err_q;

    logic start_ok;
    logic xfer;
    logic timeout;

    assign start_ok = bus.cmd_start && (bus.cmd_str_len != 6'd0) &&
                      (32'(bus.cmd_str_len) <= 32'(MAX_STR_BYTES));
    assign xfer     = (state_q == STREAM) && bus.s_valid;
    assign timeout  = (to_cnt_q == 32'(DONE_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic; abort overrides every other transition outside IDLE.
    always_comb begin
        state_d = state_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = START;
                    abort_d = 1'b0;
                end
            end
            START:     state_d = (num_bytes_q == 32'd0) ? DRAIN : STREAM;
            STREAM:    if (xfer && (byte_cnt_q == num_bytes_q - 32'd1)) state_d = DRAIN;
            DRAIN:     if (!proc_data_valid_q && (drain_cnt_q == 32'(DRAIN_CYCLES - 1)))
                           state_d = LAST;
            LAST:      state_d = abort_q ? IDLE : WAIT_DONE;
            WAIT_DONE: begin
                if (bus.proc_done)  state_d = bus.proc_match ? READOUT : REPORT;
                else if (timeout)   state_d = REPORT;
            end
            READOUT:   if (char_cnt_q == str_len_q - 6'd1) state_d = REPORT;
            REPORT:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if ((state_q != IDLE) && bus.cmd_abort) begin
            state_d = LAST;
            abort_d = 1'b1;
        end
    end

    // Batch latches, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_bytes_q       <= '0;
            str_len_q         <= '0;
            target_q          <= '0;
            proc_str_len_q    <= '0;
            byte_cnt_q        <= '0;
            drain_cnt_q       <= '0;
            to_cnt_q          <= '0;
            char_cnt_q        <= '0;
            proc_data_q       <= '0;
            proc_data_valid_q <= 1'b0;
            res_char_q        <= '0;
            res_char_valid_q  <= 1'b0;
            res_match_q       <= 1'b0;
            res_byte_pos_q    <= '0;
            err_q             <= 1'b0;
        end else begin
            err_q             <= 1'b0;
            proc_data_valid_q <= xfer;
            res_char_valid_q  <= (state_q == READOUT);
            if (xfer) proc_data_q <= bus.s_data;
            if (state_q == READOUT) res_char_q <= bus.proc_match_char;

            if (state_q == IDLE && bus.cmd_start) begin
                if (start_ok) begin
                    num_bytes_q    <= bus.cmd_num_bytes;
                    str_len_q      <= bus.cmd_str_len;
                    target_q       <= bus.cmd_target_hash;
                    proc_str_len_q <= {7'd0, bus.cmd_str_len, 3'd0};
                    res_match_q    <= 1'b0;
                    res_byte_pos_q <= '0;
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (state_q == START)      byte_cnt_q <= '0;
            else if (xfer)             byte_cnt_q <= byte_cnt_q + 32'd1;

            // Drain counting begins once the last forwarded byte has been presented.
            if (state_q != DRAIN)        drain_cnt_q <= '0;
            else if (!proc_data_valid_q) drain_cnt_q <= drain_cnt_q + 32'd1;

            to_cnt_q   <= (state_q == WAIT_DONE) ? to_cnt_q + 32'd1 : '0;
            char_cnt_q <= (state_q == READOUT) ? char_cnt_q + 6'd1 : '0;

            if (state_q == WAIT_DONE && !bus.cmd_abort) begin
                if (bus.proc_done) begin
                    res_match_q    <= bus.proc_match;
                    res_byte_pos_q <= bus.proc_byte_pos;
                end else if (timeout) begin
                    err_q          <= 1'b1;
                    res_match_q    <= 1'b0;
                    res_byte_pos_q <= '0;
                end
            end
        end
    end

    assign bus.s_ready              = (state_q == STREAM);
    assign bus.proc_start           = (state_q == START);
    assign bus.proc_last            = (state_q == LAST);
    assign bus.proc_match_char_next = (state_q == READOUT);
    assign bus.res_valid            = (state_q == REPORT);
    assign bus.busy                 = (state_q != IDLE);
    assign bus.proc_data            = proc_data_q;
    assign bus.proc_data_valid      = proc_data_valid_q;
    assign bus.proc_target_hash     = target_q;
    assign bus.proc_str_len         = proc_str_len_q;
    assign bus.res_char             = res_char_q;
    assign bus.res_char_valid       = res_char_valid_q;
    assign bus.res_match            = res_match_q;
    assign bus.res_byte_pos         = res_byte_pos_q;
    assign bus.err                  = err_q;
    assign bus.dbg_state            = state_q;
endmodule

// File: doc/md5_batch_ctrl.md
Name: md5_batch_ctrl

Overview:
- Sequencer for one string_process_match instance and its MD5 core.
- Accepts a batch command and a byte stream, then runs the batch: pulses proc_start, forwards bytes as proc_data, waits for the MD5 pipeline to drain, and asserts proc_last.
- On a match it shifts the matched string out of the match block and delivers a result record to the host side.

Parameters:
- DRAIN_CYCLES, 66: cycles to wait after the last forwarded byte before proc_last (MD5 core latency plus margin).
- MAX_STR_BYTES, 55: maximum string length in bytes (single 512-bit MD5 block).
- DONE_TIMEOUT, 16: cycles to wait for proc_done after proc_last before flagging an error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_start  in  1  start-batch pulse
- cmd_abort  in  1  abort current batch
- cmd_num_bytes  in  32  bytes in batch
- cmd_str_len  in  6  string length in bytes
- cmd_target_hash  in  128  target digest
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  stream ready
- proc_start  out  1  batch start pulse to match block
- proc_data  out  8  byte to match block
- proc_data_valid  out  1  byte valid
- proc_target_hash  out  128  latched target
- proc_str_len  out  16  string length in bits (cmd_str_len*8)
- proc_last  out  1  end-of-batch pulse
- proc_match_char_next  out  1  shift matched string by one char
- proc_done  in  1  match block done
- proc_match  in  1  match found
- proc_byte_pos  in  32  position of match
- proc_match_char  in  8  current matched char
- res_char  out  8  matched-string char
- res_char_valid  out  1  res_char valid
- res_valid  out  1  result record pulse
- res_match  out  1  batch matched
- res_byte_pos  out  32  match position
- busy  out  1  batch in progress
- err  out  1  error pulse

Behaviour:
- Reset: all outputs 0. proc_target_hash and proc_str_len are cleared. State goes to IDLE. A reset in any state aborts immediately; no pulses follow.
- States: IDLE, START, STREAM, DRAIN, LAST, WAIT_DONE, READOUT, REPORT.
- IDLE:
  - On cmd_start, latch num_bytes, target and str_len, then go to START.
  - If cmd_str_len is 0 or greater than MAX_STR_BYTES: pulse err for one cycle and stay in IDLE.
- busy is 1 in every state except IDLE.
- cmd_start outside IDLE is ignored.
- START (1 cycle): proc_start=1. proc_target_hash and proc_str_len hold the latched values from this cycle until the next accepted start. Go to STREAM, or to DRAIN if num_bytes=0.
- STREAM:
  - s_ready=1; a transfer occurs when s_valid and s_ready.
  - Each transfer registers proc_data<=s_data and proc_data_valid<=1 on the next cycle (1-cycle latency). proc_data_valid is 0 on cycles with no transfer.
  - A byte counter increments per transfer. When the num_bytes-th transfer occurs, s_ready drops on the following cycle and the state goes to DRAIN.
- DRAIN: s_ready=0. Count DRAIN_CYCLES cycles, starting the cycle after the last proc_data_valid, then go to LAST.
- LAST (1 cycle): proc_last=1, then go to WAIT_DONE.
- WAIT_DONE:
  - On proc_done=1, capture res_match<=proc_match and res_byte_pos<=proc_byte_pos.
  - If proc_match=1, go to READOUT; otherwise go to REPORT.
  - If no proc_done within DONE_TIMEOUT cycles: pulse err, set res_match=0, go to REPORT.
- READOUT (str_len cycles, one char per cycle):
  - proc_match_char_next=1 (combinational in this state).
  - res_char<=proc_match_char and res_char_valid<=1 each cycle, so the first char appears the cycle after entry.
  - After str_len chars, go to REPORT.
- REPORT (1 cycle): res_valid=1. res_match and res_byte_pos hold until the next cmd_start is accepted. Go to IDLE.
- cmd_abort in any non-IDLE state:
  - Next cycle: s_ready=0 and proc_last=1 for one cycle, then IDLE.
  - No res_valid and no err.
  - cmd_abort has priority over same-cycle state transitions.
- cmd_start and cmd_abort asserted together in IDLE: cmd_start wins.
- Byte counter and drain counter are 32-bit. A num_bytes of 0xFFFFFFFF must complete without wrap.

Test Plan:
- str_len=19, num_bytes=64, target=MD5 of the bytes at window ending pos 40, s_valid always high -> exactly 64 proc_data_valid pulses; proc_last once DRAIN_CYCLES later; res_match=1, res_byte_pos=40; 19 res_char pulses carrying the string; res_valid once.
- Same stream with a non-matching target -> no READOUT, no proc_match_char_next; res_valid with res_match=0, res_byte_pos=0.
- s_valid toggled randomly at 50% with num_bytes=10 -> proc_data byte order preserved; exactly 10 valids; s_ready low after the 10th transfer.
- cmd_str_len=0, then cmd_str_len=56 -> one err pulse each; busy stays 0; no proc_start.
- cmd_abort mid-STREAM at byte 5 -> s_ready drops; single proc_last; IDLE; no res_valid. A following cmd_start runs normally.
- num_bytes=0 -> proc_start, then proc_last after DRAIN_CYCLES; res_valid with res_match=0. Holding proc_done low -> err after DONE_TIMEOUT.
